// File: rtl/rover_pkg.sv
// Shared definitions for the rover drive-motor controller: FSM state codes,
// default PWM / duty / phase-length constants and small helper functions.
package rover_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_BRAKE   = 3'd2,
    ST_REVERSE = 3'd3,
    ST_TURN    = 3'd4
  } state_e;

  // Defaults for a 100 MHz clock: 20 kHz PWM, 0.1 s / 0.5 s / 0.3 s escape phases
  localparam int unsigned PWM_PERIOD_DEF = 5000;
  localparam int unsigned DUTY_FWD_DEF   = 3750;
  localparam int unsigned DUTY_REV_DEF   = 2500;
  localparam int unsigned DUTY_TURN_DEF  = 2500;
  localparam int unsigned BRAKE_CYC_DEF  = 10_000_000;
  localparam int unsigned REV_CYC_DEF    = 50_000_000;
  localparam int unsigned TURN_CYC_DEF   = 30_000_000;
  localparam int unsigned CRASH_FILT_DEF = 4;

  // Largest of three phase lengths, used to size the shared phase timer
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // True for the states that make up the escape sequence
  function automatic logic is_busy(input state_e s);
    return (s == ST_BRAKE) || (s == ST_REVERSE) || (s == ST_TURN);
  endfunction

endpackage

// File: rtl/rover_motor_ctrl_if.sv
// Command / motor-drive bundle of the rover motor controller.
//   en, crash          : drive request and raw crash flag (into the controller)
//   pwm_l/r, dir_l/r   : H-bridge PWM and direction (1 = forward)
//   state, busy        : current FSM state code, escape sequence in progress
interface rover_motor_ctrl_if;
  import rover_pkg::*;

  logic               en;
  logic               crash;
  logic               pwm_l;
  logic               pwm_r;
  logic               dir_l;
  logic               dir_r;
  logic [STATE_W-1:0] state;
  logic               busy;

  modport master (
    output en, crash,
    input  pwm_l, pwm_r, dir_l, dir_r, state, busy
  );

  modport slave (
    input  en, crash,
    output pwm_l, pwm_r, dir_l, dir_r, state, busy
  );

endinterface

// File: rtl/crash_filter.sv
// Debounces the proximity sensor crash flag: q only changes after CRASH_FILT
// consecutive samples of d that disagree with it.
//   clk, rst_n : clock, synchronous active-low reset
//   d          : raw crash flag
//   q          : filtered crash flag (registered, resets to 0)
module crash_filter #(
  parameter int unsigned CRASH_FILT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  localparam int unsigned CW = $clog2(CRASH_FILT + 1);

  logic [CW-1:0] cnt_q;

  // Count disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= 1'b0;
      cnt_q <= '0;
    end else if (d == q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(CRASH_FILT - 1)) begin
      q     <= d;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/rover_motor_ctrl.sv
// Two-motor rover drive controller. Drives forward while en is set; on a
// filtered crash runs brake -> reverse -> pivot-right escape, then resumes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : en/crash in; pwm_l/r, dir_l/r, state, busy out (all registered)
module rover_motor_ctrl
  import rover_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
  parameter int unsigned DUTY_FWD   = DUTY_FWD_DEF,
  parameter int unsigned DUTY_REV   = DUTY_REV_DEF,
  parameter int unsigned DUTY_TURN  = DUTY_TURN_DEF,
  parameter int unsigned BRAKE_CYC  = BRAKE_CYC_DEF,
  parameter int unsigned REV_CYC    = REV_CYC_DEF,
  parameter int unsigned TURN_CYC   = TURN_CYC_DEF,
  parameter int unsigned CRASH_FILT = CRASH_FILT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  rover_motor_ctrl_if.slave bus
);
  // Wide enough to hold PWM_PERIOD itself so duty = period compares as always-high
  localparam int unsigned PW = $clog2(PWM_PERIOD + 1);
  localparam int unsigned TW = $clog2(max3(BRAKE_CYC, REV_CYC, TURN_CYC) + 1);

  state_e        state_q;
  state_e        next_state;
  logic [TW-1:0] timer_q;
  logic [PW-1:0] pwm_cnt_q;
  logic [PW-1:0] duty_c;
  logic          dir_l_c;
  logic          dir_r_c;
  logic          pwm_q;
  logic          dir_l_q;
  logic          dir_r_q;
  logic          busy_q;
  logic          crash_f;
  logic          brake_done;
  logic          rev_done;
  logic          turn_done;

  crash_filter #(
    .CRASH_FILT (CRASH_FILT)
  ) u_crash_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.crash),
    .q     (crash_f)
  );

  // Phase ends on its last cycle so each phase lasts exactly *_CYC cycles
  assign brake_done = (timer_q == TW'(BRAKE_CYC - 1));
  assign rev_done   = (timer_q == TW'(REV_CYC - 1));
  assign turn_done  = (timer_q == TW'(TURN_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= next_state;
  end

  // Next-state logic; dropping en aborts the escape sequence immediately
  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && !crash_f) next_state = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (crash_f)      next_state = ST_BRAKE;
        else if (!bus.en) next_state = ST_IDLE;
      end
      ST_BRAKE: begin
        if (!bus.en)         next_state = ST_IDLE;
        else if (brake_done) next_state = ST_REVERSE;
      end
      ST_REVERSE: begin
        if (!bus.en)       next_state = ST_IDLE;
        else if (rev_done) next_state = ST_TURN;
      end
      ST_TURN: begin
        if (!bus.en)        next_state = ST_IDLE;
        else if (turn_done) next_state = crash_f ? ST_BRAKE : ST_DRIVE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Per-state duty and direction; IDLE/BRAKE keep the last direction
  always_comb begin
    duty_c  = '0;
    dir_l_c = dir_l_q;
    dir_r_c = dir_r_q;
    case (state_q)
      ST_DRIVE: begin
        duty_c  = PW'(DUTY_FWD);
        dir_l_c = 1'b1;
        dir_r_c = 1'b1;
      end
      ST_REVERSE: begin
        duty_c  = PW'(DUTY_REV);
        dir_l_c = 1'b0;
        dir_r_c = 1'b0;
      end
      ST_TURN: begin
        duty_c  = PW'(DUTY_TURN);
        dir_l_c = 1'b1;
        dir_r_c = 1'b0;
      end
      default: ;
    endcase
  end

  // Phase timer and PWM counter restart on every state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q   <= '0;
      pwm_cnt_q <= '0;
    end else if (next_state != state_q) begin
      timer_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      timer_q   <= is_busy(state_q) ? timer_q + TW'(1) : '0;
      pwm_cnt_q <= (pwm_cnt_q == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + PW'(1);
    end
  end

  // Output registers: PWM/dir trail state by one cycle so they never glitch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q   <= 1'b0;
      dir_l_q <= 1'b1;
      dir_r_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      pwm_q   <= (pwm_cnt_q < duty_c);
      dir_l_q <= dir_l_c;
      dir_r_q <= dir_r_c;
      busy_q  <= is_busy(next_state);
    end
  end

  assign bus.pwm_l = pwm_q;
  assign bus.pwm_r = pwm_q;
  assign bus.dir_l = dir_l_q;
  assign bus.dir_r = dir_r_q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;

endmodule
